// File: rtl/ddr1_cmd_queue.sv
// ddr1_cmd_queue: in-order host command FIFO feeding a single-outstanding
// DDR1 controller request port, with read-data return to the host.
// Optional feature macro: DDR1_CMDQ_TIMEOUT_EN adds a read-response timeout
// (TMO_CYC cycles) that returns 16'hDEAD and sets the sticky rd_err flag.
module ddr1_cmd_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic                   host_rw,
    input  logic [24:0]            host_addr,
    input  logic [15:0]            host_wdata,
    output logic                   host_rvalid,
    output logic [15:0]            host_rdata,
    output logic                   req_valid,
    output logic                   req_rw,
    output logic [24:0]            req_addr,
    output logic [15:0]            req_wdata,
    input  logic                   req_ack,
    input  logic                   resp_valid,
    input  logic [15:0]            resp_rdata,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   rd_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;

    typedef struct packed {
        logic        rw;
        logic [24:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ddr1_cmd_queue: DEPTH must be a power of two in 2..16");
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("ddr1_cmd_queue: TMO_CYC must be at least 1");
    end

    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] q_level_q, q_level_d;
    logic [1:0]       state_q, state_d;
    logic             req_valid_q, req_valid_d;
    logic             req_rw_q, req_rw_d;
    logic [24:0]      req_addr_q, req_addr_d;
    logic [15:0]      req_wdata_q, req_wdata_d;
    logic             host_rvalid_q, host_rvalid_d;
    logic [15:0]      host_rdata_q, host_rdata_d;
    logic             push;
    logic             pop;

`ifdef DDR1_CMDQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rd_err_q, rd_err_d;
`endif

    // Full is judged on current state only, so a same-cycle pop never frees a slot
    assign host_ready = (q_level_q != LVL_W'(DEPTH));
    assign push       = host_valid && host_ready;
    assign head       = mem_q[rd_ptr_q];

    // Command storage; written at the tail on every accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'{rw: host_rw, addr: host_addr, wdata: host_wdata};
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        q_level_d = q_level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   q_level_d = q_level_q + LVL_W'(1);
            2'b01:   q_level_d = q_level_q - LVL_W'(1);
            default: q_level_d = q_level_q;
        endcase
    end

    // Issue FSM: load head, hold request until ack, then await read data
    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_rw_d      = req_rw_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        pop           = 1'b0;
`ifdef DDR1_CMDQ_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rd_err_d      = rd_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (q_level_q != '0) begin
                    req_valid_d = 1'b1;
                    req_rw_d    = head.rw;
                    req_addr_d  = head.addr;
                    req_wdata_d = head.wdata;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_ack) begin
                    pop         = 1'b1;
                    req_valid_d = 1'b0;
                    state_d     = req_rw_q ? S_WAIT_RD : S_IDLE;
`ifdef DDR1_CMDQ_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            S_WAIT_RD: begin
                if (resp_valid) begin
                    host_rvalid_d = 1'b1;
                    host_rdata_d  = resp_rdata;
                    state_d       = S_IDLE;
                end
`ifdef DDR1_CMDQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    rd_err_d      = 1'b1;
                    host_rvalid_d = 1'b1;
                    host_rdata_d  = 16'hDEAD;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            q_level_q     <= '0;
            req_valid_q   <= 1'b0;
            req_rw_q      <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            q_level_q     <= q_level_d;
            req_valid_q   <= req_valid_d;
            req_rw_q      <= req_rw_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

`ifdef DDR1_CMDQ_TIMEOUT_EN
    // Read-timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rd_err_q  <= rd_err_d;
        end
    end
    assign rd_err = rd_err_q;
`else
    assign rd_err = 1'b0;
`endif

    assign req_valid   = req_valid_q;
    assign req_rw      = req_rw_q;
    assign req_addr    = req_addr_q;
    assign req_wdata   = req_wdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign q_level     = q_level_q;

endmodule
